// File: rtl/digit_seq_ctrl.sv
// rtl/digit_seq_ctrl.sv - digit table sequencer with prescaled run, stop, single-step and valid/ready output
// Optional reverse stepping: define DIGIT_SEQ_REVERSE_EN to add the dir input.
module digit_seq_ctrl #(
   parameter int DEPTH    = 8,
   parameter int DW       = 4,
   parameter int PRESCALE = 4
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef DIGIT_SEQ_REVERSE_EN
   input  logic                       dir,
`endif
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DW-1:0]              wr_data,
   input  logic [$clog2(DEPTH):0]     len,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       step,
   output logic [DW-1:0]              digit_out,
   output logic                       digit_valid,
   input  logic                       digit_ready,
   output logic                       busy,
   output logic                       wrap
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PRESENT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [LW-1:0]   len_q, len_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic            single_q, single_d;
   logic            stop_pend_q, stop_pend_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            dvalid_q, dvalid_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];

   logic [LW-1:0]   len_eff;
   logic            handshake;
   logic            at_last;
   logic            wrap_now;
   logic [AW-1:0]   idx_next;

   // Clamp requested length into 1..DEPTH and work out the post-handshake index.
   always_comb begin
      len_eff = len;
      if (len == '0) begin
         len_eff = LW'(1);
      end else if (len > LW'(DEPTH)) begin
         len_eff = LW'(DEPTH);
      end
      handshake = (state_q == S_PRESENT) && dvalid_q && digit_ready;
      at_last   = ({1'b0, idx_q} == (len_q - LW'(1)));
      wrap_now  = at_last;
      idx_next  = at_last ? '0 : (idx_q + AW'(1));
`ifdef DIGIT_SEQ_REVERSE_EN
      if (dir) begin
         wrap_now = (idx_q == '0);
         idx_next = (idx_q == '0) ? AW'(len_q - LW'(1)) : (idx_q - AW'(1));
      end
`endif
   end

   // Next-state logic for the sequencer and the digit table.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      pre_d       = pre_q;
      single_d    = single_q;
      stop_pend_d = stop_pend_q;
      dout_d      = dout_q;
      dvalid_d    = dvalid_q;
      mem_d       = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
      case (state_q)
         S_IDLE: begin
            stop_pend_d = 1'b0;
            if (!stop && start) begin
               idx_d    = '0;
               pre_d    = '0;
               single_d = 1'b0;
               len_d    = len_eff;
               state_d  = S_RUN;
            end else if (!stop && step) begin
               single_d = 1'b1;
               len_d    = len_eff;
               dout_d   = mem_q[idx_q];
               dvalid_d = 1'b1;
               state_d  = S_PRESENT;
            end
         end
         S_RUN: begin
            if (stop) begin
               pre_d   = '0;
               state_d = S_IDLE;
            end else if (pre_q == PW'(PRESCALE - 1)) begin
               dout_d   = mem_q[idx_q];
               dvalid_d = 1'b1;
               state_d  = S_PRESENT;
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         S_PRESENT: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (handshake) begin
               idx_d    = idx_next;
               dvalid_d = 1'b0;
               pre_d    = '0;
               if (single_q || stop_pend_q || stop) begin
                  stop_pend_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, presented digit and table registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         len_q       <= LW'(1);
         pre_q       <= '0;
         single_q    <= 1'b0;
         stop_pend_q <= 1'b0;
         dout_q      <= '0;
         dvalid_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         pre_q       <= pre_d;
         single_q    <= single_d;
         stop_pend_q <= stop_pend_d;
         dout_q      <= dout_d;
         dvalid_q    <= dvalid_d;
         mem_q       <= mem_d;
      end
   end

   assign digit_out   = dout_q;
   assign digit_valid = dvalid_q;
   assign busy        = (state_q != S_IDLE);
   assign wrap        = handshake && wrap_now;

endmodule
